// File: rtl/armleo_round_robin_distributor.sv
// Round-robin distributor: steers one valid/ready packet stream to one of WIDTH sinks.
// The sink is locked for a whole packet. Every beat passes through a one-entry input buffer.
module armleo_round_robin_distributor #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [WIDTH-1:0]  sink_en,
  output logic [WIDTH-1:0]  out_valid,
  input  logic [WIDTH-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [SEL_W-1:0]  out_sel,
  output logic              busy
);

  typedef enum logic {ST_SEL, ST_SEND} state_e;

  state_e             r_state, w_state_d;
  logic [SEL_W-1:0]   r_ptr, w_ptr_d;
  logic [SEL_W-1:0]   r_sel, w_sel_d;
  logic               r_buf_valid;
  logic [DATA_W-1:0]  r_buf_data;
  logic               r_buf_last;

  logic [SEL_W-1:0]   w_pick;
  logic               w_found;
  logic               w_xfer;
  logic               w_load;

  // First enabled sink scanning from the round-robin pointer upward, wrapping.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      idx = (32'(r_ptr) + i) % WIDTH;
      if (!w_found && sink_en[SEL_W'(idx)]) begin
        w_found = 1'b1;
        w_pick  = SEL_W'(idx);
      end
    end
  end

  assign w_xfer   = (r_state == ST_SEND) && r_buf_valid && out_ready[r_sel];
  assign in_ready = rst_n && (!r_buf_valid || ((r_state == ST_SEND) && out_ready[r_sel]));
  assign w_load   = in_valid && in_ready;

  // Next-state: lock a sink when a beat waits, release after the last beat drains.
  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_ptr_d   = r_ptr;
    case (r_state)
      ST_SEL: begin
        if (r_buf_valid && w_found) begin
          w_sel_d   = w_pick;
          w_state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_xfer && r_buf_last) begin
          w_state_d = ST_SEL;
          w_ptr_d   = (r_sel == SEL_W'(WIDTH - 1)) ? '0 : r_sel + SEL_W'(1);
        end
      end
      default: w_state_d = ST_SEL;
    endcase
  end

  always_comb begin
    out_valid = '0;
    if (r_state == ST_SEND) out_valid[r_sel] = r_buf_valid;
  end

  assign out_data = r_buf_data;
  assign out_last = r_buf_last;
  assign out_sel  = r_sel;
  assign busy     = (r_state == ST_SEND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_SEL;
      r_ptr       <= '0;
      r_sel       <= '0;
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
      r_buf_last  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_sel   <= w_sel_d;
      // A load in the same cycle as a drain keeps the buffer full with the new beat.
      if (w_load) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= in_data;
        r_buf_last  <= in_last;
      end else if (w_xfer) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_armleo_round_robin_distributor.sv
// Bench for armleo_round_robin_distributor: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_armleo_round_robin_distributor;
  localparam int unsigned W  = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [W-1:0]  sink_en;
  logic [W-1:0]  out_valid;
  logic [W-1:0]  out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_sel;
  logic          busy;

  always #5 clk = ~clk;

  armleo_round_robin_distributor #(.WIDTH(W), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .sink_en(sink_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: m_lock = sink owning the current packet, -1 when none.
  int            m_lock = -1;
  int            m_ptr  = 0;
  int            m_sel  = 0;
  bit            m_have = 0;
  logic [DW-1:0] m_data = '0;
  bit            m_last = 0;
  bit            m_ok   = 0;
  bit            m_xfer, m_load, m_found;
  int            m_idx;
  int            cyc = 0;

  function automatic bit m_ready();
    return rst_n && (!m_have || (m_lock >= 0 && out_ready[m_lock] == 1'b1));
  endfunction

  function automatic logic [W-1:0] m_valid();
    return (m_lock >= 0 && m_have) ? W'(1 << m_lock) : '0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_lock = -1; m_ptr = 0; m_sel = 0; m_have = 0; m_data = '0; m_last = 0; m_ok = 1;
    end else if (m_ok) begin
      m_xfer = (m_lock >= 0) && m_have && (out_ready[m_lock] == 1'b1);
      m_load = in_valid && m_ready();
      if (m_lock < 0) begin
        if (m_have && sink_en != '0) begin
          m_found = 0;
          for (int k = 0; k < W; k++) begin
            m_idx = (m_ptr + k) % W;
            if (!m_found && sink_en[m_idx] == 1'b1) begin
              m_found = 1; m_lock = m_idx; m_sel = m_idx;
            end
          end
        end
      end else if (m_xfer && m_last) begin
        m_ptr  = (m_lock + 1) % W;
        m_lock = -1;
      end
      if (m_load) begin
        m_have = 1; m_data = in_data; m_last = in_last;
      end else if (m_xfer) begin
        m_have = 0;
      end
    end
  end

  // Delivered-beat log and per-cycle comparison against the model.
  int            log_sink[$];
  logic [DW-1:0] log_data[$];
  int            log_cyc[$];
  logic [W-1:0]  seen_valid = '0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("in_ready",  64'(in_ready),  64'(m_ready()));
      chk("out_valid", 64'(out_valid), 64'(m_valid()));
      chk("busy",      64'(busy),      64'(m_lock >= 0));
      chk("out_sel",   64'(out_sel),   64'(m_sel));
      chk("out_data",  64'(out_data),  64'(m_data));
      chk("out_last",  64'(out_last),  64'(m_last));
      seen_valid |= out_valid;
      if (rst_n && |(out_valid & out_ready)) begin
        log_sink.push_back(int'(out_sel));
        log_data.push_back(out_data);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit l);
    int t;
    bit acc;
    t = 0; acc = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready;
      step();
      t++;
    end
    in_valid = 1'b0;
    chk("beat_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_log(input int n);
    int t;
    t = 0;
    while (log_sink.size() < n && t < 60) begin
      step();
      t++;
    end
    chk("delivered_count", 64'(log_sink.size()), 64'(n));
  endtask

  task automatic clear_log();
    log_sink.delete(); log_data.delete(); log_cyc.delete();
    seen_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic chk_sink(input int i, input int s, input logic [DW-1:0] d);
    if (i < log_sink.size()) begin
      chk($sformatf("sink_%0d", i), 64'(log_sink[i]), 64'(s));
      chk($sformatf("data_%0d", i), 64'(log_data[i]), 64'(d));
    end else begin
      chk($sformatf("missing_beat_%0d", i), 64'(log_sink.size()), 64'(i + 1));
    end
  endtask

  initial begin
    int exp1[5];
    int exp2[3];
    exp1 = '{0, 1, 2, 3, 0};
    exp2 = '{1, 3, 1};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    sink_en = '0; out_ready = '0;
    step();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_out_sel",   64'(out_sel),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    step();
    rst_n = 1'b1;

    // Five single-beat packets rotate over all sinks.
    sink_en = 4'hF; out_ready = 4'hF;
    for (int i = 0; i < 5; i++) send_beat(32'hD0 + 32'(i), 1'b1);
    wait_log(5);
    for (int i = 0; i < 5; i++) chk_sink(i, exp1[i], 32'hD0 + 32'(i));

    // Only sinks 1 and 3 enabled.
    do_reset();
    sink_en = 4'b1010;
    for (int i = 0; i < 3; i++) send_beat(32'hE0 + 32'(i), 1'b1);
    wait_log(3);
    for (int i = 0; i < 3; i++) chk_sink(i, exp2[i], 32'hE0 + 32'(i));
    chk("disabled_sinks_valid", 64'(seen_valid & 4'b0101), 64'd0);

    // Three-beat packet stalled mid-packet, then pointer moved to sink 1.
    do_reset();
    sink_en = 4'hF; out_ready = 4'hF;
    send_beat(32'hA, 1'b0);
    send_beat(32'hB, 1'b0);
    out_ready = 4'h0;
    step();
    @(negedge clk);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_data",  64'(out_data),  64'hB);
    step();
    out_ready = 4'hF;
    send_beat(32'hC, 1'b1);
    send_beat(32'hF, 1'b1);
    wait_log(4);
    chk_sink(0, 0, 32'hA);
    chk_sink(1, 0, 32'hB);
    chk_sink(2, 0, 32'hC);
    chk_sink(3, 1, 32'hF);

    // Beat parked while no sink is eligible.
    do_reset();
    sink_en = 4'h0;
    send_beat(32'h55, 1'b1);
    step(); step(); step();
    @(negedge clk);
    chk("park_out_valid", 64'(out_valid), 64'd0);
    chk("park_in_ready",  64'(in_ready),  64'd0);
    chk("park_busy",      64'(busy),      64'd0);
    step();
    sink_en = 4'b0100;
    wait_log(1);
    chk_sink(0, 2, 32'h55);

    // Eight-beat stream followed by a packet after one bubble.
    do_reset();
    sink_en = 4'hF; out_ready = 4'hF;
    for (int i = 0; i < 8; i++) send_beat(32'h100 + 32'(i), i == 7);
    send_beat(32'h200, 1'b1);
    wait_log(9);
    if (log_cyc.size() >= 9) begin
      for (int i = 0; i < 7; i++)
        chk($sformatf("stream_gap_%0d", i), 64'(log_cyc[i+1] - log_cyc[i]), 64'd1);
      chk("packet_bubble", 64'(log_cyc[8] - log_cyc[7]), 64'd2);
      chk_sink(7, 0, 32'h107);
      chk_sink(8, 1, 32'h200);
    end

    // Reset in the middle of a packet locked to sink 1.
    do_reset();
    sink_en = 4'hF; out_ready = 4'hF;
    send_beat(32'h30, 1'b1);
    send_beat(32'h31, 1'b0);
    send_beat(32'h32, 1'b0);
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy",      64'(busy),      64'd0);
    chk("midrst_out_sel",   64'(out_sel),   64'd0);
    step();
    clear_log();
    send_beat(32'h40, 1'b1);
    wait_log(1);
    chk_sink(0, 0, 32'h40);

    // Random traffic with occasional resets; the model checks every cycle.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      in_last   = ($urandom % 3) == 0;
      if ($urandom % 16 == 0) sink_en = W'($urandom);
      out_ready = W'($urandom);
      rst_n     = ($urandom % 300) != 0;
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
